// File: rtl/mipi_pkg.sv
// Shared types and constants for the MIPI capture path: arbiter states,
// channel limits and CSI-2 short-packet data types.
package mipi_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, GAP, ABORT} arb_state_t;

    localparam int MAX_CAM = 4;

    localparam logic [7:0] MIPI_FRAME_START = 8'h00;
    localparam logic [7:0] MIPI_FRAME_END   = 8'h01;
    localparam logic [7:0] MIPI_ROW_START   = 8'h02;

    // Index width for n channels; never below one bit so a 1-entry select stays legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mipi_frame_arbiter_if.sv
// Per-camera extractor signals plus the shared AXI-Stream DMA port.
// The arbiter is the stream master toward the DMA.
interface mipi_frame_arbiter_if #(parameter int NUM_CAM = 2);
    logic [NUM_CAM-1:0]   s_new_frame;
    logic [8*NUM_CAM-1:0] s_pixel_data;
    logic [NUM_CAM-1:0]   s_pixel_valid;
    logic [NUM_CAM-1:0]   s_row_done;
    logic [NUM_CAM-1:0]   s_frame_done;
    logic [NUM_CAM-1:0]   s_dma_ready;
    logic [7:0]           m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tuser;
    logic [1:0]           m_tdest;
    logic                 m_tready;
    logic [9:0]           row_cnt;

    modport master (
        input  s_new_frame, s_pixel_data, s_pixel_valid, s_row_done, s_frame_done, m_tready,
        output s_dma_ready, m_tdata, m_tvalid, m_tlast, m_tuser, m_tdest, row_cnt
    );

    modport slave (
        output s_new_frame, s_pixel_data, s_pixel_valid, s_row_done, s_frame_done, m_tready,
        input  s_dma_ready, m_tdata, m_tvalid, m_tlast, m_tuser, m_tdest, row_cnt
    );
endinterface

// File: rtl/mipi_frame_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', wrapping.
module rr_pick
    import mipi_pkg::*;
#(
    parameter int N = 2,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         found
);

    always_comb begin
        int c;
        grant = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last) + k) % N;
            if (!found && req[W'(c)]) begin
                found = 1'b1;
                grant = W'(c);
            end
        end
    end

endmodule

// File: rtl/mipi_frame_arbiter.sv
// Shares one DMA stream between NUM_CAM extractors, a whole frame per grant,
// round-robin, with a forced idle gap between frames and a stall watchdog.
module mipi_frame_arbiter
    import mipi_pkg::*;
#(
    parameter int NUM_CAM    = 2,
    parameter int ROW_NUM    = 800,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mipi_frame_arbiter_if.master        bus,
    output logic [7:0]                  dropped_frames,
    output logic                        timeout_err
);

    localparam int GW = idx_w(NUM_CAM);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(GAP_CYCLES + 1);

    if (NUM_CAM < 2 || NUM_CAM > MAX_CAM || ROW_NUM > 1023 || GAP_CYCLES < 1) begin : g_param_check
        $error("mipi_frame_arbiter: unsupported parameter set");
    end

    arb_state_t                 state;
    logic [GW-1:0]              grant, last_grant, pick;
    logic                       found;
    logic [NUM_CAM-1:0]         pend, gmask, pick_mask, active_mask, clr, drops;
    logic [NUM_CAM-1:0][7:0]    pix;
    logic                       sof_pending, streaming, sinking, g_valid, g_done;
    logic [9:0]                 row_cnt;
    logic [IW-1:0]              idle_cnt;
    logic [CW-1:0]              gap_cnt;
    logic [1:0]                 tdest;
    logic [2:0]                 drop_n;
    logic [8:0]                 drop_sum;

    rr_pick #(.N(NUM_CAM), .W(GW)) u_pick (
        .req   (pend),
        .last  (last_grant),
        .grant (pick),
        .found (found)
    );

    assign pix         = bus.s_pixel_data;
    assign streaming   = (state == STREAM);
    assign sinking     = (state == ABORT);
    assign gmask       = NUM_CAM'(1) << grant;
    assign pick_mask   = NUM_CAM'(1) << pick;
    assign active_mask = (streaming || sinking) ? gmask : '0;
    assign clr         = (state == IDLE && found) ? pick_mask : '0;
    assign g_valid     = bus.s_pixel_valid[grant];
    assign g_done      = bus.s_frame_done[grant];

    // Zero-latency forwarding from the registered grant.
    assign bus.m_tvalid    = streaming & g_valid;
    assign bus.m_tdata     = streaming ? pix[grant] : '0;
    assign bus.m_tlast     = streaming & g_valid & bus.s_row_done[grant];
    assign bus.m_tuser     = sof_pending & bus.m_tvalid;
    assign bus.m_tdest     = tdest;
    assign bus.s_dma_ready = streaming ? (gmask & {NUM_CAM{bus.m_tready}})
                           : (sinking ? gmask : '0);
    assign bus.row_cnt     = row_cnt;

    // A start pulse is lost if that channel already waits or currently owns the DMA.
    assign drops = bus.s_new_frame & (pend | active_mask);

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_CAM; i++) drop_n = drop_n + 3'(drops[i]);
    end

    assign drop_sum = {1'b0, dropped_frames} + 9'(drop_n);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            grant          <= '0;
            last_grant     <= GW'(NUM_CAM - 1);
            pend           <= '0;
            tdest          <= '0;
            sof_pending    <= 1'b0;
            row_cnt        <= '0;
            idle_cnt       <= '0;
            gap_cnt        <= '0;
            dropped_frames <= '0;
            timeout_err    <= 1'b0;
        end else begin
            pend           <= (pend | (bus.s_new_frame & ~active_mask)) & ~clr;
            dropped_frames <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            case (state)
                IDLE: begin
                    if (found) begin
                        grant       <= pick;
                        last_grant  <= pick;
                        tdest       <= 2'(pick);
                        row_cnt     <= '0;
                        idle_cnt    <= '0;
                        sof_pending <= 1'b1;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.m_tvalid && bus.m_tready) sof_pending <= 1'b0;
                    if (bus.m_tlast && bus.m_tready) row_cnt <= row_cnt + 10'd1;
                    if (g_done) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (g_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IW'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state       <= ABORT;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                ABORT: begin
                    if (g_done) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == CW'(GAP_CYCLES - 1)) state <= IDLE;
                    else gap_cnt <= gap_cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
